// File: rtl/rv_exec_core.sv
// Single-cycle RV32I OP/OP-IMM execution core with word-addressed instruction memory.
// Optional LUI/AUIPC support is enabled by defining CORE_LUI_AUIPC_EN.
module rv_exec_core #(
  parameter int IMEM_AW = 10
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [31:0]        pc,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        instr,
  output logic               we,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [31:0]        rrs1,
  output logic [31:0]        rrs2,
  output logic [31:0]        result
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
`ifdef CORE_LUI_AUIPC_EN
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`endif

  logic [31:0] mem [2**IMEM_AW];
  logic [31:0] xreg [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] op_b;
  logic [31:0] sra_out;
  logic [31:0] alu_out;
  logic        is_op;
  logic        known;

  // Memory has no reset; a same-edge write is only visible to fetch after the edge.
  always_ff @(posedge CLK) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  assign instr = mem[pc[IMEM_AW+1:2]];

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  // Entry 0 is kept cleared and never written, but reads of x0 are masked anyway.
  assign rrs1 = (rs1 == 5'd0) ? 32'd0 : xreg[rs1];
  assign rrs2 = (rs2 == 5'd0) ? 32'd0 : xreg[rs2];

  assign is_op   = (opcode == OPC_OP);
  assign op_b    = is_op ? rrs2 : imm_i;
  assign sra_out = $signed(rrs1) >>> op_b[4:0];

  // instr[30] picks SUB only for register-register ops; it picks SRA/SRAI for both.
  always_comb begin
    alu_out = 32'd0;
    case (funct3)
      3'b000:  alu_out = (is_op && instr[30]) ? (rrs1 - op_b) : (rrs1 + op_b);
      3'b001:  alu_out = rrs1 << op_b[4:0];
      3'b010:  alu_out = {31'd0, ($signed(rrs1) < $signed(op_b))};
      3'b011:  alu_out = {31'd0, (rrs1 < op_b)};
      3'b100:  alu_out = rrs1 ^ op_b;
      3'b101:  alu_out = instr[30] ? sra_out : (rrs1 >> op_b[4:0]);
      3'b110:  alu_out = rrs1 | op_b;
      default: alu_out = rrs1 & op_b;
    endcase
  end

`ifdef CORE_LUI_AUIPC_EN
  logic [31:0] imm_u;
  assign imm_u = {instr[31:12], 12'd0};
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:IMEM_AW+2], pc[1:0]};
`endif

  always_comb begin
    known  = 1'b0;
    result = 32'd0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        known  = 1'b1;
        result = alu_out;
      end
`ifdef CORE_LUI_AUIPC_EN
      OPC_LUI: begin
        known  = 1'b1;
        result = imm_u;
      end
      OPC_AUIPC: begin
        known  = 1'b1;
        result = pc + imm_u;
      end
`endif
      default: begin
        known  = 1'b0;
        result = 32'd0;
      end
    endcase
  end

  assign we = RST_X & known;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      xreg <= '{default: 32'd0};
    end else if (we && (rd != 5'd0)) begin
      xreg[rd] <= result;
    end
  end

endmodule

// File: tb/tb_rv_exec_core.sv
// Bench for rv_exec_core: directed program, vector table, corner sequences and
// random instructions against an arithmetic reference model.
module tb_rv_exec_core;

  localparam int AW = 10;
  localparam logic [31:0] WMASK = ((32'd1 << AW) - 32'd1) << 2;

  logic          CLK;
  logic          RST_X;
  logic [31:0]   pc;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   instr;
  logic          we;
  logic [4:0]    rs1, rs2, rd;
  logic [31:0]   rrs1, rrs2, result;

  int total = 0;
  int bad   = 0;

  logic [31:0] mreg [32];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] word;
    logic [4:0]  chk_reg;
    logic [31:0] exp_val;
    logic        exp_we;
  } vec_t;

  vec_t vecs [$];

  rv_exec_core #(.IMEM_AW(AW)) dut (
    .CLK(CLK), .RST_X(RST_X), .pc(pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instr(instr), .we(we), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rrs1(rrs1), .rrs2(rrs2), .result(result)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, expv);
    end
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  // Reference model: instruction semantics computed with 64-bit integer arithmetic.
  task automatic ref_exec(input logic [31:0] w, input logic [31:0] pcv,
                          output logic ewe, output logic [31:0] eres);
    longint ua, ub, sa, sb, p, q;
    logic [31:0] a, b;
    logic [6:0]  opc;
    logic [4:0]  sh;
    logic        alt;
    opc  = w[6:0];
    a    = mreg[w[19:15]];
    ewe  = 1'b0;
    eres = 32'd0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      ewe = 1'b1;
      b   = (opc == 7'b0110011) ? mreg[w[24:20]] : {{20{w[31]}}, w[31:20]};
      alt = w[30];
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sh  = b[4:0];
      p   = longint'(1) << sh;
      case (w[14:12])
        3'd0: eres = (opc == 7'b0110011 && alt) ? 32'(ua - ub) : 32'(ua + ub);
        3'd1: eres = 32'(ua * p);
        3'd2: eres = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: eres = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: eres = a ^ b;
        3'd5: begin
          if (!alt) q = ua / p;
          else if (sa >= 0) q = sa / p;
          else q = -((-sa + p - 1) / p);
          eres = 32'(q);
        end
        3'd6: eres = a | b;
        default: eres = a & b;
      endcase
    end
`ifdef CORE_LUI_AUIPC_EN
    else if (opc == 7'b0110111) begin
      ewe  = 1'b1;
      eres = {w[31:12], 12'h000};
    end else if (opc == 7'b0010111) begin
      ewe  = 1'b1;
      eres = 32'(longint'(pcv) + longint'({w[31:12], 12'h000}));
    end
`endif
  endtask

  // driver: word 0 stays a zero word (no-op); the instruction under test goes in word 1
  task automatic exec(input logic [31:0] w, input logic [31:0] pcv, input string tag,
                      output logic we_seen);
    logic        ewe;
    logic [31:0] eres;
    pc = 32'd0;
    load_word(1, w);
    pc = (pcv & ~WMASK) | 32'd4;
    #2;
    ref_exec(w, pc, ewe, eres);
    exp_q.push_back(eres);
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_we"}, {31'd0, we}, {31'd0, ewe});
    chk({tag, "_fields"}, {17'd0, rs1, rs2, rd}, {17'd0, w[19:15], w[24:20], w[11:7]});
    chk({tag, "_rrs1"}, rrs1, mreg[w[19:15]]);
    chk({tag, "_rrs2"}, rrs2, mreg[w[24:20]]);
    chk({tag, "_result"}, result, exp_q.pop_front());
    we_seen = we;
    tick();
    if (ewe && w[11:7] != 5'd0) mreg[w[11:7]] = eres;
  endtask

  // reads x[n] through rs1 of an opcode-0 word, which never writes
  task automatic check_reg(input logic [4:0] n, input logic [31:0] expv, input string name);
    pc = 32'd0;
    load_word(1, {12'h000, n, 3'b000, 5'd0, 7'd0});
    pc = 32'd4;
    #2;
    chk(name, rrs1, expv);
  endtask

  task automatic gen_instr(output logic [31:0] w);
    logic [31:0] r;
    logic [4:0]  rd_v, rs1_v, rs2_v;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  opc;
    int k;
    r     = $urandom();
    rd_v  = 5'($urandom_range(0, 31));
    rs1_v = 5'($urandom_range(0, 31));
    rs2_v = 5'($urandom_range(0, 31));
    f3    = 3'($urandom_range(0, 7));
    imm   = r[11:0];
    k     = $urandom_range(0, 9);
    if (k <= 3) begin
      opc = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      w = {opc, rs2_v, rs1_v, f3, rd_v, 7'b0110011};
    end else if (k <= 7) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      w = {imm, rs1_v, f3, rd_v, 7'b0010011};
    end else if (k == 8) begin
      w = {r[31:12], rd_v, ($urandom_range(0, 1) == 1) ? 7'b0110111 : 7'b0010111};
    end else begin
      do opc = 7'($urandom_range(0, 127));
      while (opc == 7'b0110011 || opc == 7'b0010011 || opc == 7'b0110111 || opc == 7'b0010111);
      w = {r[31:7], opc};
    end
  endtask

  initial begin
    logic [31:0] prog [4];
    logic [31:0] w;
    logic        ws;
    logic        lui_on;
`ifdef CORE_LUI_AUIPC_EN
    lui_on = 1'b1;
`else
    lui_on = 1'b0;
`endif
    RST_X      = 1'b0;
    pc         = 32'd0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = 32'd0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;

    prog[0] = 32'h00000000;
    prog[1] = 32'hFD000293;
    prog[2] = 32'h02A00313;
    prog[3] = 32'h006283B3;

    vecs.push_back('{32'h00000000, 5'd7,  32'hFFFFFFFA, 1'b0});
    vecs.push_back('{32'h40628433, 5'd8,  32'hFFFFFFA6, 1'b1});
    vecs.push_back('{32'h4042D493, 5'd9,  32'hFFFFFFFD, 1'b1});
    vecs.push_back('{32'h01C2D513, 5'd10, 32'h0000000F, 1'b1});
    vecs.push_back('{32'h0062A5B3, 5'd11, 32'h00000001, 1'b1});
    vecs.push_back('{32'h0062B633, 5'd12, 32'h00000000, 1'b1});
    vecs.push_back('{32'h00500013, 5'd0,  32'h00000000, 1'b1});
    vecs.push_back('{32'h123456B7, 5'd13, lui_on ? 32'h12345000 : 32'h0, lui_on});
    vecs.push_back('{32'h0062B633, 5'd5,  32'hFFFFFFD0, 1'b1});

    // directed program, loaded while held in reset
    for (int i = 0; i < 4; i++) load_word(AW'(i), prog[i]);
    pc = 32'd4;
    #2;
    chk("rst_we", {31'd0, we}, 32'd0);
    tick();
    pc    = 32'd0;
    RST_X = 1'b1;
    #2;
    chk("p0_we", {31'd0, we}, 32'd0);
    chk("p0_result", result, 32'd0);
    tick();
    pc = 32'd4;
    #2;
    chk("p1_we", {31'd0, we}, 32'd1);
    chk("p1_result", result, 32'hFFFFFFD0);
    tick();
    pc = 32'd8;
    #2;
    chk("p2_result", result, 32'd42);
    chk("p2_rrs1", rrs1, 32'd0);
    tick();
    pc = 32'd12;
    #2;
    chk("p3_rrs1", rrs1, 32'hFFFFFFD0);
    chk("p3_rrs2", rrs2, 32'd42);
    chk("p3_result", result, 32'hFFFFFFFA);
    tick();
    mreg[5] = 32'hFFFFFFD0;
    mreg[6] = 32'd42;
    mreg[7] = 32'hFFFFFFFA;

    // vector table
    foreach (vecs[i]) begin
      exec(vecs[i].word, 32'd0, $sformatf("tbl%0d", i), ws);
      chk($sformatf("tbl%0d_we_tbl", i), {31'd0, ws}, {31'd0, vecs[i].exp_we});
      check_reg(vecs[i].chk_reg, vecs[i].exp_val, $sformatf("tbl%0d_reg", i));
    end

    // load and fetch of the same word on one edge: old word executes
    pc = 32'd0;
    load_word(2, 32'h00300793);
    pc         = 32'd8;
    imem_we    = 1'b1;
    imem_waddr = 2;
    imem_wdata = 32'h00900793;
    #2;
    chk("coll_old_instr", instr, 32'h00300793);
    chk("coll_old_result", result, 32'd3);
    tick();
    imem_we = 1'b0;
    #1;
    chk("coll_new_instr", instr, 32'h00900793);
    chk("coll_new_result", result, 32'd9);
    mreg[15] = 32'd3;
    check_reg(5'd15, 32'd3, "coll_x15");

    // random instructions, random high pc bits and pc[1:0]
    for (int i = 0; i < 400; i++) begin
      gen_instr(w);
      exec(w, $urandom(), $sformatf("rnd%0d", i), ws);
    end
    for (int n = 0; n < 32; n++) check_reg(5'(n), mreg[n], $sformatf("rnd_x%0d", n));

    // reset pulse mid-program
    exec(32'hFD000293, 32'd0, "mid_pre", ws);
    pc = 32'd0;
    load_word(1, 32'h00128713);
    pc = 32'd4;
    #2;
    chk("mid_before_rrs1", rrs1, 32'hFFFFFFD0);
    RST_X = 1'b0;
    #1;
    chk("mid_clear_rrs1", rrs1, 32'd0);
    chk("mid_clear_we", {31'd0, we}, 32'd0);
    tick();
    tick();
    chk("mid_hold_rrs1", rrs1, 32'd0);
    chk("mid_hold_we", {31'd0, we}, 32'd0);
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    RST_X = 1'b1;
    #2;
    chk("mid_first_we", {31'd0, we}, 32'd1);
    chk("mid_first_result", result, 32'd1);
    tick();
    mreg[14] = 32'd1;
    check_reg(5'd14, 32'd1, "mid_x14");
    check_reg(5'd5, 32'd0, "mid_x5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
